// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller.
//   state_e     : controller state, value doubles as the 2-bit mode output
//                 (00 RUN, 01 SET_HR, 10 SET_MIN)
//   BLANK_*     : bit positions of each digit in the 4-bit blank mask
//   DEF_*       : default timing constants for a 50 MHz system clock
//   cnt_width() : counter width for a cycle count, never below 1 bit
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_e;

    localparam int unsigned BLANK_HR_HI  = 3;
    localparam int unsigned BLANK_HR_LO  = 2;
    localparam int unsigned BLANK_MIN_HI = 1;
    localparam int unsigned BLANK_MIN_LO = 0;

    localparam int unsigned DEF_HOLD_CYCLES    = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES  = 10_000_000;
    localparam int unsigned DEF_BLINK_CYCLES   = 25_000_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000_000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus auto-repeat for a debounced button level.
//   clk, rst : system clock, synchronous active-high reset
//   level    : debounced button level
//   clear    : drops any hold in progress and suppresses the pulse this cycle
//   pulse    : one-cycle pulse on the rising edge, then after HOLD_CYCLES
//              of continuous hold, then every REPEAT_CYCLES while held
module btn_repeat
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic clear,
    output logic pulse
);

    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    localparam int unsigned RW = cnt_width(REPEAT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_START = (HOLD_CYCLES > 1) ? HW'(1) : '0;

    logic          prev_q, prev_d;
    logic          armed_q, armed_d;
    logic          rep_phase_q, rep_phase_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rise;

    assign rise = level & ~prev_q;

    // hold_cnt counts cycles since the rise (the rise cycle is 0); once it
    // reaches HOLD_LAST the first repeat fires and rep_cnt takes over.
    always_comb begin
        prev_d      = level;
        armed_d     = armed_q;
        rep_phase_d = rep_phase_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        pulse       = 1'b0;
        if (clear || !level) begin
            armed_d     = 1'b0;
            rep_phase_d = 1'b0;
            hold_cnt_d  = '0;
            rep_cnt_d   = '0;
        end else if (rise) begin
            armed_d     = 1'b1;
            rep_phase_d = 1'b0;
            hold_cnt_d  = HOLD_START;
            rep_cnt_d   = '0;
            pulse       = 1'b1;
        end else if (armed_q) begin
            if (!rep_phase_q) begin
                if (hold_cnt_q == HOLD_LAST) begin
                    pulse       = 1'b1;
                    rep_phase_d = 1'b1;
                    rep_cnt_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end else if (rep_cnt_q == REP_LAST) begin
                pulse     = 1'b1;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 1'b1;
            armed_q     <= 1'b0;
            rep_phase_q <= 1'b0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
        end else begin
            prev_q      <= prev_d;
            armed_q     <= armed_d;
            rep_phase_q <= rep_phase_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting mode controller for the digital clock.
//   clk, rst   : system clock, synchronous active-high reset
//   run_sw     : run switch level; clock counts only in RUN with run_sw high
//   btn_mode   : debounced mode button, each press steps RUN->SET_HR->SET_MIN->RUN
//   btn_inc    : debounced increment button, with auto-repeat while held
//   clk_en     : registered count enable to the clock datapath
//   hrup/minup : registered one-cycle hour/minute increment pulses
//   mode       : current state (00 RUN, 01 SET_HR, 10 SET_MIN)
//   blank_mask : per-digit blank, blinks the field being edited
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
    parameter int unsigned BLINK_CYCLES   = DEF_BLINK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_sw,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       clk_en,
    output logic       hrup,
    output logic       minup,
    output logic [1:0] mode,
    output logic [3:0] blank_mask
);

    localparam int unsigned BW = cnt_width(BLINK_CYCLES);
    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic          mode_prev_q, mode_prev_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;      // 1 = digits visible
    logic          clk_en_q, clk_en_d;
    logic          hrup_q, hrup_d;
    logic          minup_q, minup_d;
    logic [3:0]    blank_q, blank_d;
    logic          mode_rise;
    logic          inc_pulse;
    logic          timeout_hit;

    // Kept outside the always_comb so the clear -> inc_pulse path through
    // btn_repeat does not form a loop through a single block.
    assign mode_rise = btn_mode & ~mode_prev_q;

    btn_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_inc_repeat (
        .clk  (clk),
        .rst  (rst),
        .level(btn_inc),
        .clear(mode_rise),
        .pulse(inc_pulse)
    );

    always_comb begin
        mode_prev_d = btn_mode;

        // An increment in the last idle cycle counts as activity and wins.
        timeout_hit = (state_q != ST_RUN) && (to_cnt_q == TO_LAST) && !inc_pulse;

        state_d = state_q;
        if (mode_rise) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HR;
                ST_SET_HR: state_d = ST_SET_MIN;
                default:   state_d = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_RUN;
        end

        // inc_pulse is already suppressed by btn_repeat on a mode rise.
        hrup_d  = inc_pulse && (state_q == ST_SET_HR);
        minup_d = inc_pulse && (state_q == ST_SET_MIN);

        if (state_d == ST_RUN || mode_rise || inc_pulse) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        if (state_d != state_q || hrup_d || minup_d || state_d == ST_RUN) begin
            phase_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            phase_d     = ~phase_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        // Mask and enable follow the next state so they line up with mode.
        blank_d = '0;
        case (state_d)
            ST_SET_HR: begin
                blank_d[BLANK_HR_HI] = ~phase_d;
                blank_d[BLANK_HR_LO] = ~phase_d;
            end
            ST_SET_MIN: begin
                blank_d[BLANK_MIN_HI] = ~phase_d;
                blank_d[BLANK_MIN_LO] = ~phase_d;
            end
            default: ;
        endcase

        clk_en_d = run_sw && (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b1;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            clk_en_q    <= 1'b0;
            hrup_q      <= 1'b0;
            minup_q     <= 1'b0;
            blank_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= mode_prev_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            clk_en_q    <= clk_en_d;
            hrup_q      <= hrup_d;
            minup_q     <= minup_d;
            blank_q     <= blank_d;
        end
    end

    assign mode       = state_q;
    assign clk_en     = clk_en_q;
    assign hrup       = hrup_q;
    assign minup      = minup_q;
    assign blank_mask = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with short timing parameters. A cycle-level
// reference model built from elapsed-time arithmetic checks every output on
// every cycle; a vector table and directed sequences cover the scenarios
// with hand-derived expected values.
module tb_clock_set_ctrl;

    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int BLINK = 3;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       rst, run_sw, btn_mode, btn_inc;
    logic       clk_en, hrup, minup;
    logic [1:0] mode;
    logic [3:0] blank_mask;

    clock_set_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .BLINK_CYCLES  (BLINK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run_sw    (run_sw),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .clk_en    (clk_en),
        .hrup      (hrup),
        .minup     (minup),
        .mode      (mode),
        .blank_mask(blank_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // index of the cycle whose inputs are being applied

    // Reference model state: 0 RUN, 1 SET_HR, 2 SET_MIN
    int m_state, m_rise_t, m_idle, m_blink_t;
    bit m_prev_mode, m_prev_inc, m_armed;
    bit e_clk_en, e_hrup, e_minup;
    logic [1:0] e_mode;
    logic [3:0] e_blank;

    int hr_q[$], min_q[$], hr_blank_q[$];

    typedef struct {
        bit r, rs, bm, bi;
        logic [1:0] md;
        bit ce, hu, mu;
        logic [3:0] bl;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Computes the outputs registered at the end of cycle cyc.
    task automatic model_step(input bit r, input bit rs, input bit bm, input bit bi);
        int  t;
        int  nstate;
        int  d;
        bit  mrise, irise, pulse, vis;
        t = cyc;
        if (r) begin
            m_state = 0; m_prev_mode = 1'b1; m_prev_inc = 1'b1; m_armed = 1'b0;
            m_idle = 0; m_blink_t = t + 1;
            e_mode = 2'b00; e_clk_en = 1'b0; e_hrup = 1'b0; e_minup = 1'b0; e_blank = 4'b0000;
            return;
        end
        mrise = bm && !m_prev_mode;
        irise = bi && !m_prev_inc;
        m_prev_mode = bm;
        m_prev_inc  = bi;

        pulse = 1'b0;
        if (mrise || !bi) begin
            m_armed = 1'b0;
        end else if (irise) begin
            m_armed = 1'b1; m_rise_t = t; pulse = 1'b1;
        end else if (m_armed) begin
            d = t - m_rise_t + 1;   // cycle offset at which this pulse would appear
            if (d >= HOLD && ((d - HOLD) % REP) == 0) pulse = 1'b1;
        end

        nstate = m_state;
        if (mrise) begin
            nstate = (m_state + 1) % 3;
            m_idle = 0;
        end else if (m_state != 0) begin
            if (pulse) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle >= TMO) nstate = 0;
            end
        end
        if (nstate == 0) m_idle = 0;

        e_hrup  = pulse && (m_state == 1);
        e_minup = pulse && (m_state == 2);
        if (nstate != m_state || e_hrup || e_minup || nstate == 0) m_blink_t = t + 1;
        vis = (((t + 1 - m_blink_t) / BLINK) % 2) == 0;
        e_blank = 4'b0000;
        if (!vis) begin
            if (nstate == 1) e_blank = 4'b1100;
            else if (nstate == 2) e_blank = 4'b0011;
        end
        e_clk_en = rs && (nstate == 0);
        e_mode   = 2'(nstate);
        m_state  = nstate;
    endtask

    task automatic tick(input bit r, input bit rs, input bit bm, input bit bi);
        rst = r; run_sw = rs; btn_mode = bm; btn_inc = bi;
        model_step(r, rs, bm, bi);
        @(posedge clk);
        #1;
        cyc++;
        chk("model_mode", int'(mode), int'(e_mode));
        chk("model_clk_en", int'(clk_en), int'(e_clk_en));
        chk("model_hrup", int'(hrup), int'(e_hrup));
        chk("model_minup", int'(minup), int'(e_minup));
        chk("model_blank", int'(blank_mask), int'(e_blank));
        if (hrup) begin
            hr_q.push_back(cyc);
            hr_blank_q.push_back(int'(blank_mask));
        end
        if (minup) min_q.push_back(cyc);
    endtask

    task automatic run_n(input int n, input bit rs, input bit bm, input bit bi);
        for (int i = 0; i < n; i++) tick(1'b0, rs, bm, bi);
    endtask

    task automatic clear_rec();
        hr_q.delete();
        min_q.delete();
        hr_blank_q.delete();
    endtask

    function automatic vec_t mk(input bit r, input bit rs, input bit bm, input bit bi,
                                input logic [1:0] md, input bit ce, input bit hu,
                                input bit mu, input logic [3:0] bl);
        vec_t v;
        v.r = r; v.rs = rs; v.bm = bm; v.bi = bi;
        v.md = md; v.ce = ce; v.hu = hu; v.mu = mu; v.bl = bl;
        return v;
    endfunction

    initial begin
        int r0, m0, found;
        bit rs_l, bm_l, bi_l;

        // reset with mode held, release, run, then cycle through all modes
        tbl.push_back(mk(1,0,1,0, 2'd0,0,0,0, 4'b0000));
        tbl.push_back(mk(1,0,1,0, 2'd0,0,0,0, 4'b0000));
        tbl.push_back(mk(0,0,1,0, 2'd0,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,1,0, 2'd0,1,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd0,1,0,0, 4'b0000));
        tbl.push_back(mk(0,1,1,0, 2'd1,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd1,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd1,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd1,0,0,0, 4'b1100));
        tbl.push_back(mk(0,1,0,0, 2'd1,0,0,0, 4'b1100));
        tbl.push_back(mk(0,1,0,0, 2'd1,0,0,0, 4'b1100));
        tbl.push_back(mk(0,1,0,0, 2'd1,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,1,0, 2'd2,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd2,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd2,0,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd2,0,0,0, 4'b0011));
        tbl.push_back(mk(0,1,0,0, 2'd2,0,0,0, 4'b0011));
        tbl.push_back(mk(0,1,1,0, 2'd0,1,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd0,1,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,1, 2'd0,1,0,0, 4'b0000));   // inc ignored in RUN
        tbl.push_back(mk(0,1,0,1, 2'd0,1,0,0, 4'b0000));
        tbl.push_back(mk(0,1,0,0, 2'd0,1,0,0, 4'b0000));

        foreach (tbl[i]) begin
            tick(tbl[i].r, tbl[i].rs, tbl[i].bm, tbl[i].bi);
            chk($sformatf("tbl%0d_mode", i), int'(mode), int'(tbl[i].md));
            chk($sformatf("tbl%0d_clk_en", i), int'(clk_en), int'(tbl[i].ce));
            chk($sformatf("tbl%0d_hrup", i), int'(hrup), int'(tbl[i].hu));
            chk($sformatf("tbl%0d_minup", i), int'(minup), int'(tbl[i].mu));
            chk($sformatf("tbl%0d_blank", i), int'(blank_mask), int'(tbl[i].bl));
        end

        // single increment in SET_HR
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        clear_rec();
        r0 = cyc;
        run_n(5, 1, 0, 1);
        run_n(6, 1, 0, 0);
        chk("single_hr_count", hr_q.size(), 1);
        if (hr_q.size() == 1) begin
            chk("single_hr_time", hr_q[0], r0 + 1);
            chk("single_hr_blank", hr_blank_q[0], 0);
        end
        chk("single_min_count", min_q.size(), 0);

        // auto-repeat in SET_MIN
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        clear_rec();
        r0 = cyc;
        run_n(20, 1, 0, 1);
        run_n(8, 1, 0, 0);
        chk("repeat_min_count", min_q.size(), 5);
        if (min_q.size() == 5) begin
            chk("repeat_p0", min_q[0], r0 + 1);
            chk("repeat_p1", min_q[1], r0 + 8);
            chk("repeat_p2", min_q[2], r0 + 12);
            chk("repeat_p3", min_q[3], r0 + 16);
            chk("repeat_p4", min_q[4], r0 + 20);
        end
        chk("repeat_hr_count", hr_q.size(), 0);

        // back to RUN, then idle timeout from SET_HR
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        m0 = cyc;
        tick(0, 1, 1, 0);
        found = -1;
        for (int i = 0; i < 40 && found < 0; i++) begin
            tick(0, 1, 0, 0);
            if (mode == 2'b00) found = cyc;
        end
        chk("timeout_idle", found, m0 + 21);

        // timeout pushed out by an increment 15 cycles after entry
        m0 = cyc;
        tick(0, 1, 1, 0);
        while (cyc < m0 + 15) tick(0, 1, 0, 0);
        clear_rec();
        tick(0, 1, 0, 1);
        found = -1;
        for (int i = 0; i < 50 && found < 0; i++) begin
            tick(0, 1, 0, 0);
            if (mode == 2'b00) found = cyc;
        end
        chk("timeout_pushed", found, m0 + 36);
        chk("timeout_pushed_hr", hr_q.size(), 1);

        // mode and inc rise together in SET_HR
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        clear_rec();
        tick(0, 1, 1, 1);
        chk("collision_mode", int'(mode), 2);
        run_n(10, 1, 0, 1);
        tick(0, 1, 0, 0);
        chk("collision_hr", hr_q.size(), 0);
        chk("collision_min", min_q.size(), 0);

        // reset in the middle of a hold in SET_MIN
        clear_rec();
        tick(0, 1, 0, 1);
        run_n(4, 1, 0, 1);
        tick(1, 1, 0, 1);
        chk("midreset_mode", int'(mode), 0);
        run_n(12, 1, 0, 1);
        chk("midreset_min", min_q.size(), 1);

        // randomized levels against the model
        rs_l = 1'b1; bm_l = 1'b0; bi_l = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) rs_l = ~rs_l;
            if ($urandom_range(0, 29) == 0) bm_l = ~bm_l;
            if ($urandom_range(0, 9) == 0) bi_l = ~bi_l;
            tick($urandom_range(0, 299) == 0, rs_l, bm_l, bi_l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode controller that sequences time-setting for the digital clock datapath. It converts debounced mode/increment button levels into single-cycle hrup/minup pulses, with auto-repeat while the increment button is held. It gates the clock's count enable while editing and drives a per-digit blank mask so the seven-segment driver blinks the field being edited. It sits between the debouncers and the digital_clock/sevenseg_driver instances in the top level.

Parameters:
HOLD_CYCLES, 50_000_000, cycles btn_inc must stay high after its rising edge before the first auto-repeat pulse
REPEAT_CYCLES, 10_000_000, cycles between subsequent auto-repeat pulses while held
BLINK_CYCLES, 25_000_000, cycles per blink half-period
TIMEOUT_CYCLES, 1_000_000_000, inactivity cycles in a SET state before returning to RUN

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
run_sw  in  1  user run switch (level)
btn_mode  in  1  debounced mode button (level)
btn_inc  in  1  debounced increment button (level)
clk_en  out  1  count enable to the clock datapath
hrup  out  1  one-cycle hour-increment pulse
minup  out  1  one-cycle minute-increment pulse
mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN
blank_mask  out  4  1 = blank digit; [3:2] hour digits, [1:0] minute digits

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset: state RUN; clk_en=0, hrup=0, minup=0, mode=00, blank_mask=0000; all counters 0; blink phase=visible; button-prev registers=1, so a button held through reset produces no edge.
- Edges: rise = level & ~prev, registered each cycle.
- FSM: mode rise advances RUN->SET_HR->SET_MIN->RUN. The transition takes effect on the next cycle.
- mode output equals the state encoding, registered.
- clk_en (registered) = run_sw & (state==RUN). Editing therefore freezes the time.
- Increment pulses:
  - Trigger: inc rise sampled in cycle N.
  - Response: hrup (SET_HR) or minup (SET_MIN) is high in cycle N+1 only.
  - In RUN, inc is ignored and no pulse is generated.
- Auto-repeat:
  - A hold counter starts at the inc rise.
  - If btn_inc is still high HOLD_CYCLES cycles after the rise, emit one pulse.
  - Then emit one pulse every REPEAT_CYCLES cycles while btn_inc stays high.
  - Release clears the counter immediately. No pulse is emitted on the cycle btn_inc is low.
- Blink:
  - Phase toggles every BLINK_CYCLES cycles while in a SET state.
  - Phase forces to visible, with the counter cleared, on every state change and every hrup/minup pulse.
  - SET_HR: blank_mask = {off,off,0,0}. SET_MIN: blank_mask = {0,0,off,off}. RUN: 0000. off = ~phase.
- Timeout:
  - The inactivity counter runs in SET states.
  - It is cleared by any mode rise, inc rise or repeat pulse.
  - On reaching TIMEOUT_CYCLES-1, state goes to RUN.
  - The counter is held at 0 in RUN.
- Simultaneous mode rise and inc rise: mode wins. No pulse is emitted and the hold counter clears.
- A mode change while inc is held stops auto-repeat. A new inc rise is needed to re-arm it.
- Never assert hrup and minup in the same cycle.
- rst mid-hold or mid-SET: immediate return to reset values next cycle, with no pulse.
- Counter widths are $clog2 of the respective parameter, minimum 1. Counters saturate and do not wrap.

Decomposition:
- Package clock_pkg holds:
  - state encodings RUN/SET_HR/SET_MIN as 2-bit localparams
  - blank-mask field positions
  - default timing constants
- One natural sub-module, btn_repeat:
  - contains the edge detect, hold counter and repeat counter
  - outputs a one-cycle pulse
  - has a clear input driven by the mode rise
- The FSM, blink generator and timeout stay in clock_set_ctrl.

Test Plan:
All scenarios use HOLD_CYCLES=8, REPEAT_CYCLES=4, BLINK_CYCLES=3, TIMEOUT_CYCLES=20.
- Reset check: assert rst 2 cycles with btn_mode=1 held -> all outputs 0, mode=00; releasing rst with btn_mode still high gives no state change; clk_en=1 one cycle after run_sw=1.
- Mode cycling: 3 separate btn_mode pulses -> mode 01, 10, 00 in turn; clk_en=0 in 01/10; blank_mask toggles 1100/0000 every 3 cycles in SET_HR and 0011/0000 in SET_MIN.
- Single increment: SET_HR, btn_inc high for 5 cycles -> exactly one hrup, one cycle after the rise; minup stays 0; blank_mask=0000 on the pulse cycle.
- Auto-repeat: SET_MIN, btn_inc held 20 cycles -> minup at rise+1, rise+8, rise+12, rise+16, rise+20 (5 pulses), none after release.
- Timeout: enter SET_HR and idle -> mode returns to 00 after 20 cycles; an inc pulse at cycle 15 pushes the return to 20 cycles after it.
- Collision: btn_mode and btn_inc rise in the same cycle in SET_HR -> mode=10, no hrup/minup; inc held 10 more cycles -> no repeat pulses.
